alu_issue_4bit: RTL and testbench
=================================

# alu_issue_4bit

Sequential command issuer and result collector for the team's 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives the ALU operand/select inputs from registers. After a configurable settle time it samples ALU_Out/Cout/Zero and returns them over a second valid/ready handshake. An optional accumulator lets a command reuse the previous result as the X operand.

## Interface
- SETTLE_CYCLES, 1, cycles operands are held on the ALU before sampling; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  3  ALU select code.
- cmd_a  in  4  X operand.
- cmd_b  in  4  Y operand.
- cmd_use_acc  in  1  use the accumulator as X instead of cmd_a; active only under ALU_ISSUE_CHAIN_EN.
- X  out  4  registered ALU operand X.
- Y  out  4  registered ALU operand Y.
- ALU_Sel  out  3  registered ALU select.
- ALU_Out  in  4  ALU result.
- Cout  in  1  ALU carry/borrow (bit 4 of the 5-bit result).
- Zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_data  out  4  captured ALU_Out.
- rsp_cout  out  1  captured Cout.
- rsp_zero  out  1  captured Zero.
- op_cnt  out  8  count of completed responses; wraps 255 -> 0.

## Operation
- Opcode map driven on ALU_Sel: 000 add, 001 sub, 010 AND, 011 OR, 100 NAND, 101 XOR, 110 XNOR, 111 NOR.
- IDLE: cmd_ready=1. On accept:
  - load X (cmd_a, or acc when chaining), Y=cmd_b, ALU_Sel=cmd_op;
  - load settle counter with SETTLE_CYCLES-1;
  - go SETTLE.
- SETTLE: cmd_ready=0. Counter decrements each cycle. On the edge where the counter is 0:
  - capture ALU_Out/Cout/Zero into rsp_data/rsp_cout/rsp_zero;
  - acc <= ALU_Out;
  - go RESP.
- RESP: rsp_valid=1, and response outputs are held stable until the handshake completes.
  - cmd_ready = rsp_ready.
  - On rsp_ready: op_cnt increments. Go SETTLE if cmd_valid, loading the new command exactly as from IDLE; otherwise go IDLE.
- X/Y/ALU_Sel change only on command acceptance. They hold their last values in IDLE and RESP.
- The block performs no arithmetic. Width and flag semantics come entirely from the ALU: 4-bit result; Cout is bit 4 of the 5-bit add/sub result and 0 for logic ops.
- Reset (any state, including mid-SETTLE): state IDLE and in-flight command discarded. Outputs reset to: X, Y, ALU_Sel, rsp_data, acc = 0; rsp_cout, rsp_zero, rsp_valid = 0; op_cnt = 0; cmd_ready = 0 while rst is high, then 1.

## Timing
- Command accepted at edge N -> response captured at edge N+SETTLE_CYCLES. rsp_valid is high from that edge onward.
- Sustained throughput with rsp_ready held high: one op per SETTLE_CYCLES+1 cycles.
- Response accept and new command accept may occur on the same edge.
- rsp_valid never drops without a handshake, except on reset.
- cmd_* inputs are sampled only at the accept edge and are don't-care otherwise.

## Configuration
- ALU_ISSUE_CHAIN_EN defined:
  - accumulator implemented;
  - cmd_use_acc=1 drives X from acc, which holds the most recently captured ALU_Out (0 after reset).
- Not defined:
  - no accumulator register;
  - cmd_use_acc ignored and X always taken from cmd_a;
  - port list unchanged.

## Test plan
- Add with carry, SETTLE_CYCLES=1: op 000, a=7, b=9 -> one cycle after accept, rsp_data=0, rsp_cout=1, rsp_zero=1, op_cnt=1 after handshake.
- Subtract with borrow: op 001, a=3, b=5 -> rsp_data=4'hE, rsp_cout=1, rsp_zero=0.
- Chaining (ALU_ISSUE_CHAIN_EN): add a=4, b=3 -> 7; then op 011, use_acc=1, a=0, b=8 -> X=7, rsp_data=4'hF. Without the macro the second op returns 8.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, X/Y unchanged. Release -> new command accepted on the same edge as the response.
- Reset mid-op, SETTLE_CYCLES=3: assert rst one cycle after accept -> rsp_valid stays 0, all outputs 0, op_cnt=0, and the next command completes normally.
- Counter wrap: issue 256 back-to-back XOR ops with rsp_ready=1 -> op_cnt returns to 0, and throughput is one op per 2 cycles.

Source files
------------

// File: rtl/alu_issue_4bit.sv
// Command issuer / result collector wrapped around a 4-bit combinational ALU.
// Optional accumulator chaining is built only when ALU_ISSUE_CHAIN_EN is defined.
module alu_issue_4bit #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [2:0] ALU_Sel,
    input  logic [3:0] ALU_Out,
    input  logic       Cout,
    input  logic       Zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_cout,
    output logic       rsp_zero,
    output logic [7:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [3:0] x_next;
    logic       accept;
    logic       capture;

    assign accept  = cmd_valid && cmd_ready;
    assign capture = (state == SETTLE) && (settle_cnt == 4'd0);

`ifdef ALU_ISSUE_CHAIN_EN
    logic [3:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (capture) begin
            acc <= ALU_Out;
        end
    end

    assign x_next = cmd_use_acc ? acc : cmd_a;
`else
    logic unused_use_acc;

    assign unused_use_acc = cmd_use_acc;
    assign x_next         = cmd_a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                cmd_ready = rsp_ready;
                if (rsp_ready) begin
                    state_next = cmd_valid ? SETTLE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Hold off new commands for the whole time reset is asserted.
        if (rst) begin
            cmd_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            X          <= '0;
            Y          <= '0;
            ALU_Sel    <= '0;
            settle_cnt <= '0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
            rsp_zero   <= 1'b0;
            op_cnt     <= '0;
        end else begin
            if (accept) begin
                X          <= x_next;
                Y          <= cmd_b;
                ALU_Sel    <= cmd_op;
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                rsp_data <= ALU_Out;
                rsp_cout <= Cout;
                rsp_zero <= Zero;
            end
            if ((state == RESP) && rsp_ready) begin
                op_cnt <= op_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_4bit.sv
// Scoreboard bench for alu_issue_4bit: driver pushes model results on accept,
// monitor compares held response outputs each cycle and pops on handshake.
module tb_alu_issue_4bit;

    localparam int unsigned S = 3;
    localparam int PERIOD = 10;
`ifdef ALU_ISSUE_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic       cmd_use_acc = 1'b0;
    logic [3:0] X, Y;
    logic [2:0] ALU_Sel;
    logic [3:0] ALU_Out;
    logic       Cout, Zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_cout, rsp_zero;
    logic [7:0] op_cnt;

    always #(PERIOD / 2) clk = ~clk;

    alu_issue_4bit #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .X(X), .Y(Y), .ALU_Sel(ALU_Sel),
        .ALU_Out(ALU_Out), .Cout(Cout), .Zero(Zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
        .op_cnt(op_cnt)
    );

    // Stand-in for the team's combinational ALU.
    logic [4:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (ALU_Sel)
            3'b000: alu_r = {1'b0, X} + {1'b0, Y};
            3'b001: alu_r = {1'b0, X} - {1'b0, Y};
            3'b010: alu_r = {1'b0, X & Y};
            3'b011: alu_r = {1'b0, X | Y};
            3'b100: alu_r = {1'b0, ~(X & Y)};
            3'b101: alu_r = {1'b0, X ^ Y};
            3'b110: alu_r = {1'b0, ~(X ^ Y)};
            default: alu_r = {1'b0, ~(X | Y)};
        endcase
    end
    assign ALU_Out = alu_r[3:0];
    assign Cout    = alu_r[4];
    assign Zero    = (alu_r[3:0] == 4'd0);

    typedef struct {
        int      op;
        int      x;
        int      y;
        int      data;
        int      cout;
        int      zero;
        longint  t;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_acc = 0;
    int   exp_cnt = 0;
    bit   head_seen = 1'b0;
    bit   rand_rdy = 1'b0;
    exp_t e;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics in plain integer arithmetic on values 0..15.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int data, output int cout, output int zero);
        cout = 0;
        case (op)
            0: begin data = (a + b) % 16; cout = (a + b > 15) ? 1 : 0; end
            1: begin data = (a - b + 16) % 16; cout = (a < b) ? 1 : 0; end
            2: data = a & b;
            3: data = a | b;
            4: data = 15 - (a & b);
            5: data = a ^ b;
            6: data = 15 - (a ^ b);
            default: data = 15 - (a | b);
        endcase
        zero = (data == 0) ? 1 : 0;
    endfunction

    task automatic do_push(input int op, input int a, input int b, input int u);
        exp_t n;
        n.op = op;
        n.x  = (u != 0 && CHAIN) ? m_acc : a;
        n.y  = b;
        ref_alu(n.op, n.x, n.y, n.data, n.cout, n.zero);
        n.t  = $time;
        m_acc = n.data;
        q.push_back(n);
    endtask

    task automatic send(input int op, input int a, input int b, input int u);
        bit ok = 1'b0;
        cmd_op = 3'(op); cmd_a = 4'(a); cmd_b = 4'(b); cmd_use_acc = 1'(u);
        cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                do_push(op, a, b, u);
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        bit ok = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", {X, Y, ALU_Sel, rsp_data, rsp_cout, rsp_zero, rsp_valid, op_cnt}, 0);
        check("reset_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0;
        @(negedge clk);
        check("post_reset_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    // Monitor: compare the head entry while a response is held, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = 0;
            head_seen = 1'b0;
        end else begin
            check("op_cnt", op_cnt, exp_cnt % 256);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("spurious_rsp_valid", 1, 0);
                end else begin
                    e = q[0];
                    if (!head_seen) begin
                        check("latency", $time - e.t, (S + 1) * PERIOD);
                        head_seen = 1'b1;
                    end
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_cout", rsp_cout, e.cout);
                    check("rsp_zero", rsp_zero, e.zero);
                    check("X_held", X, e.x);
                    check("Y_held", Y, e.y);
                    check("ALU_Sel_held", ALU_Sel, e.op);
                    check("resp_cmd_ready", cmd_ready, rsp_ready);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        exp_cnt++;
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t_prev;
        int     count;
        @(posedge clk); #1;
        do_reset();

        // Directed: add with carry, subtract with borrow, chaining.
        rsp_ready = 1'b1;
        send(0, 7, 9, 0);
        send(1, 3, 5, 0);
        send(0, 4, 3, 0);
        send(3, 0, 8, 1);
        drain();

        // Backpressure, then same-edge response/command handshake.
        rsp_ready = 1'b0;
        send(5, 10, 6, 0);
        cmd_op = 3'd2; cmd_a = 4'd12; cmd_b = 4'd10; cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        repeat (S + 5) begin
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("same_edge_ready", cmd_ready, 1);
        check("same_edge_valid", rsp_valid, 1);
        do_push(2, 12, 10, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();

        // Reset one cycle after accept, mid-settle.
        send(0, 5, 5, 0);
        do_reset();

        // 256 back-to-back XOR ops: wrap and throughput.
        rsp_ready = 1'b1;
        count = 0;
        t_prev = 0;
        cmd_op = 3'd5; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 2000 && count < 256; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                do_push(5, int'(cmd_a), int'(cmd_b), 0);
                if (count > 0) check("throughput", $time - t_prev, (S + 1) * PERIOD);
                t_prev = $time;
                count++;
            end
            @(posedge clk); #1;
            cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        end
        cmd_valid = 1'b0;
        check("burst_count", count, 256);
        drain();
        @(negedge clk);
        check("op_cnt_wrap", op_cnt, 0);
        @(posedge clk); #1;

        // Randomized commands with random response backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        rand_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
